counter_multimode: RTL and testbench

Parametrised, multi-mode synchronous counter; successor to the fixed 8-bit load/count counter used in the interconnect test designs. It adds generic width, up/down counting, enable gating, free-run, modulo and one-shot modes, a registered terminal-count pulse and a sticky done flag. It sits as a leaf user-area block, driven directly by the top-level bench or by a control FSM. SDF back-annotation is run against its gate-level netlist.

---
 rtl/counter_multimode.sv | 108 ++++++++++
 tb/tb_counter_multimode.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_multimode.sv
// Multi-mode up/down counter (free-run, modulo, one-shot, hold) with registered TC pulse and sticky DONE.
// One edge from sampled inputs to C/TC/DONE; no handshake, ENABLE=0 or MODE=hold simply freezes C.
module counter_multimode #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
`ifdef USE_POWER_PINS
    inout  wire              vccd1,
    inout  wire              vssd1,
`endif
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] VALUE,
    input  logic             DIR,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] LIMIT,
    output logic [WIDTH-1:0] C,
    output logic             TC,
    output logic             DONE
);

    typedef enum logic [1:0] {
        MODE_FREE    = 2'b00,
        MODE_MODULO  = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = '0;

    mode_t            mode_sel;
    logic [WIDTH-1:0] c_up;
    logic [WIDTH-1:0] c_dn;
    logic [WIDTH-1:0] c_step;
    logic [WIDTH-1:0] c_nxt;
    logic             tc_nxt;
    logic             done_nxt;

    assign mode_sel = mode_t'(MODE);
    assign c_up     = C + ONE;
    assign c_dn     = C - ONE;
    assign c_step   = DIR ? c_dn : c_up;

    always_comb begin
        c_nxt    = C;
        tc_nxt   = 1'b0;
        done_nxt = DONE;
        if (LOAD) begin
            c_nxt    = VALUE;
            done_nxt = 1'b0;
        end else if (ENABLE) begin
            case (mode_sel)
                MODE_FREE: begin
                    c_nxt  = c_step;
                    tc_nxt = DIR ? (C == ZERO) : (C == ALL_ONES);
                end
                MODE_MODULO: begin
                    if (!DIR) begin
                        // Values above LIMIT (e.g. after a load) also wrap to zero.
                        if (C >= LIMIT) begin
                            c_nxt  = ZERO;
                            tc_nxt = 1'b1;
                        end else begin
                            c_nxt = c_up;
                        end
                    end else begin
                        if (C == ZERO) begin
                            c_nxt  = LIMIT;
                            tc_nxt = 1'b1;
                        end else begin
                            c_nxt = c_dn;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (!DONE) begin
                        if (C == LIMIT) begin
                            done_nxt = 1'b1;
                            tc_nxt   = 1'b1;
                        end else begin
                            c_nxt = c_step;
                        end
                    end
                end
                MODE_HOLD: begin
                    c_nxt = C;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            C    <= RESET_VALUE;
            TC   <= 1'b0;
            DONE <= 1'b0;
        end else begin
            C    <= c_nxt;
            TC   <= tc_nxt;
            DONE <= done_nxt;
        end
    end

endmodule

// File: tb/tb_counter_multimode.sv
// Bench for counter_multimode: directed scenarios followed by random stimulus against an arithmetic reference model.
module tb_counter_multimode;

    localparam int W    = 8;
    localparam int MODV = 1 << W;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         load;
    logic [W-1:0] value;
    logic         dir;
    logic [1:0]   mode;
    logic [W-1:0] limit;
    logic [W-1:0] c;
    logic         tc;
    logic         done;

    int n_checks;
    int n_errors;

    int m_c;
    bit m_tc;
    bit m_done;

    counter_multimode #(.WIDTH(W), .RESET_VALUE(8'd0)) dut (
        .CLK    (clk),
        .RESET  (rst),
        .ENABLE (enable),
        .LOAD   (load),
        .VALUE  (value),
        .DIR    (dir),
        .MODE   (mode),
        .LIMIT  (limit),
        .C      (c),
        .TC     (tc),
        .DONE   (done)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_c    = 0;
        m_tc   = 0;
        m_done = 0;
    endtask

    // Reference behaviour written directly from the mode rules, using int arithmetic mod 2^W.
    task automatic model_edge();
        int lim;
        lim  = int'(limit);
        m_tc = 0;
        if (load) begin
            m_c    = int'(value);
            m_done = 0;
        end else if (enable) begin
            case (int'(mode))
                0: begin
                    if (!dir) begin
                        m_tc = (m_c == MODV - 1);
                        m_c  = (m_c + 1) % MODV;
                    end else begin
                        m_tc = (m_c == 0);
                        m_c  = (m_c + MODV - 1) % MODV;
                    end
                end
                1: begin
                    if (!dir) begin
                        if (m_c >= lim) begin
                            m_c  = 0;
                            m_tc = 1;
                        end else begin
                            m_c = m_c + 1;
                        end
                    end else begin
                        if (m_c == 0) begin
                            m_c  = lim;
                            m_tc = 1;
                        end else begin
                            m_c = m_c - 1;
                        end
                    end
                end
                2: begin
                    if (!m_done) begin
                        if (m_c == lim) begin
                            m_done = 1;
                            m_tc   = 1;
                        end else begin
                            m_c = dir ? (m_c + MODV - 1) % MODV : (m_c + 1) % MODV;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".c"},    32'(c),    32'(m_c));
        check({tag, ".tc"},   32'(tc),   32'(m_tc));
        check({tag, ".done"}, 32'(done), 32'(m_done));
    endtask

    task automatic cycle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare_all(tag);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst    = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        value  = '0;
        dir    = 1'b0;
        mode   = 2'b00;
        limit  = '0;
        model_reset();

        #5;
        compare_all("reset");
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset_hold");
        rst = 1'b0;

        // Free-run up through a full wrap 255 -> 0.
        enable = 1'b1;
        cycle("free_up", 258);

        // Load wins over enable for two cycles, then counting resumes.
        load  = 1'b1;
        value = 8'd42;
        cycle("load", 2);
        load = 1'b0;
        cycle("after_load", 3);

        // Free-run down across 0 -> 255.
        load = 1'b1; value = 8'd2;
        cycle("load_dn", 1);
        load = 1'b0; dir = 1'b1;
        cycle("free_dn", 4);
        dir = 1'b0;

        // Modulo with LIMIT 5, both directions, then LIMIT 0.
        load = 1'b1; value = 8'd0; mode = 2'b01; limit = 8'd5;
        cycle("mod_load", 1);
        load = 1'b0;
        cycle("mod_up", 14);
        dir = 1'b1;
        cycle("mod_dn", 14);
        dir = 1'b0; limit = 8'd0;
        cycle("mod_lim0", 5);

        // One-shot from 250 up to 3, wrapping through 0.
        mode = 2'b10; limit = 8'd3; load = 1'b1; value = 8'd250;
        cycle("os_load", 1);
        load = 1'b0;
        cycle("oneshot", 12);
        load = 1'b1; value = 8'd0;
        cycle("os_reload", 1);
        load = 1'b0;
        cycle("os_resume", 2);
        // Loading exactly LIMIT finishes on the next enabled edge.
        load = 1'b1; value = 8'd3;
        cycle("os_ld_lim", 1);
        load = 1'b0;
        cycle("os_at_lim", 2);

        // Enable gating and hold mode.
        mode = 2'b00; load = 1'b1; value = 8'd100;
        cycle("en_load", 1);
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            enable = ~enable;
            cycle("enable", 3);
        end
        enable = 1'b1; mode = 2'b11;
        cycle("hold", 4);

        // Asynchronous reset between edges while a one-shot is in progress.
        mode = 2'b10; limit = 8'd10; load = 1'b1; value = 8'd0;
        cycle("ar_load", 1);
        load = 1'b0;
        cycle("ar_count", 2);
        check("ar_pre_c", 32'(c), 32'd2);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst");
        #3;
        rst = 1'b0;
        cycle("ar_resume", 3);

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            load   = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 3) != 0);
            value  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) limit = 8'($urandom_range(0, 255));
            cycle("rand", 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
